// File: rtl/seq_booth_mult_if.sv
// Handshake bundle for seq_booth_mult: operand request side and product response side.
interface seq_booth_mult_if #(parameter int WIDTH = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, one partial-product step per clock,
// signed or unsigned per transaction, valid/ready on both sides.
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_booth_mult_if.slave  bus
);
  localparam int AW = 2*WIDTH + 4;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      acc;
  logic [WIDTH+1:0]   ext_a;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH+1:0]   upper, sum;
  logic [AW-1:0]      step_acc;
  logic               accept, sgn_a, sgn_b;

  assign accept = bus.in_valid && (state == IDLE);
  assign sgn_a  = bus.signed_mode & bus.a[WIDTH-1];
  assign sgn_b  = bus.signed_mode & bus.b[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (cnt == '0)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.busy      = (state == BUSY);
    bus.out_valid = (state == DONE);
  end

  assign bus.p = p_q;

  // Upper half carries two guard bits so add/sub of ext_a cannot wrap before the shift.
  assign upper = acc[AW-1:WIDTH+2];
  always_comb begin
    case (acc[1:0])
      2'b01:   sum = upper + ext_a;
      2'b10:   sum = upper - ext_a;
      default: sum = upper;
    endcase
  end
  assign step_acc = {sum[WIDTH+1], sum, acc[WIDTH+1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ext_a <= '0;
      cnt   <= '0;
      p_q   <= '0;
    end else if (accept) begin
      acc   <= {{(WIDTH+2){1'b0}}, sgn_b, bus.b, 1'b0};
      ext_a <= {{2{sgn_a}}, bus.a};
      cnt   <= CW'(WIDTH);
    end else if (state == BUSY) begin
      acc <= step_acc;
      if (cnt == '0) p_q <= step_acc[2*WIDTH:1];
      else           cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_booth_mult.sv
// Scoreboard bench for seq_booth_mult at WIDTH=4 (directed + exhaustive) and WIDTH=8 (directed).
module tb_seq_booth_mult;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_booth_mult_if #(.WIDTH(4)) i4();
  seq_booth_mult_if #(.WIDTH(8)) i8();
  seq_booth_mult #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  seq_booth_mult #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));

  int n_chk = 0, n_fail = 0;
  int n_push4 = 0, n_res4 = 0;
  logic [7:0]  exp4[$];
  logic [15:0] exp8[$];
  bit rnd_en = 1'b0;
  logic ready_req = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic m);
    int sx, sy, pr;
    sx = m ? int'($signed(x)) : int'(x);
    sy = m ? int'($signed(y)) : int'(y);
    pr = sx * sy;
    return pr[7:0];
  endfunction

  // Single driver of out_ready on the 4-bit port; offset from the edge and from negedge sampling.
  initial forever begin
    @(posedge clk); #3;
    i4.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : ready_req;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && i4.out_valid && i4.out_ready) begin
      n_res4++;
      if (exp4.size() == 0) chk("w4_extra_result", 32'(i4.p), 32'hFFFF_FFFF);
      else                  chk("w4_p", 32'(i4.p), 32'(exp4.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && i8.out_valid && i8.out_ready) begin
      if (exp8.size() == 0) chk("w8_extra_result", 32'(i8.p), 32'hFFFF_FFFF);
      else                  chk("w8_p", 32'(i8.p), 32'(exp8.pop_front()));
    end
  end

  task automatic send4(input logic [3:0] ta, input logic [3:0] tb, input logic tm,
                       input logic [7:0] ex, input bit lat);
    int t = 0;
    i4.a = ta; i4.b = tb; i4.signed_mode = tm; i4.in_valid = 1'b1;
    while (!i4.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("w4_accept_timeout", 32'(t), 32'd0);
    exp4.push_back(ex); n_push4++;
    @(posedge clk); #1;
    i4.in_valid = 1'b0; i4.a = 4'($urandom); i4.b = 4'($urandom); i4.signed_mode = ~tm;
    if (lat) begin
      t = 0;
      while (!i4.out_valid && t < 100) begin @(posedge clk); #1; t++; end
      chk("w4_latency", 32'(t), 32'd5);
    end
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                       input logic [15:0] ex);
    int t = 0;
    i8.a = ta; i8.b = tb; i8.signed_mode = tm; i8.in_valid = 1'b1;
    while (!i8.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("w8_accept_timeout", 32'(t), 32'd0);
    exp8.push_back(ex);
    @(posedge clk); #1;
    i8.in_valid = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
    t = 0;
    while (!i8.out_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("w8_latency", 32'(t), 32'd9);
  endtask

  task automatic drain(input int lim);
    int t = 0;
    while ((exp4.size() != 0 || exp8.size() != 0) && t < lim) begin @(posedge clk); #1; t++; end
    if (t >= lim) chk("drain_timeout", 32'(exp4.size() + exp8.size()), 32'd0);
  endtask

  initial begin
    i4.in_valid = 1'b0; i4.a = '0; i4.b = '0; i4.signed_mode = 1'b0; i4.out_ready = 1'b1;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.signed_mode = 1'b0; i8.out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(i4.in_ready), 32'd1);
    chk("rst_out_valid", 32'(i4.out_valid), 32'd0);
    chk("rst_busy", 32'(i4.busy), 32'd0);
    chk("rst_p", 32'(i4.p), 32'd0);
    chk("rst_p8", 32'(i8.p), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    send4(4'b1000, 4'b1000, 1'b1, 8'h40, 1'b1);
    send4(4'hF, 4'hF, 1'b0, 8'hE1, 1'b1);
    send4(4'hF, 4'hF, 1'b1, 8'h01, 1'b1);
    send8(8'hC8, 8'h03, 1'b1, 16'hFF58);
    send8(8'd200, 8'd255, 1'b0, 16'hC738);
    drain(200);

    // Backpressure: result held, stray operands ignored.
    ready_req = 1'b0;
    send4(4'd5, 4'd6, 1'b0, 8'h1E, 1'b0);
    begin
      int t = 0;
      while (!i4.out_valid && t < 50) begin @(posedge clk); #1; t++; end
      chk("bp_reach_done", 32'(i4.out_valid), 32'd1);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_p_stable", 32'(i4.p), 32'h1E);
      chk("bp_in_ready", 32'(i4.in_ready), 32'd0);
      chk("bp_out_valid", 32'(i4.out_valid), 32'd1);
      i4.in_valid = (i % 2 == 0); i4.a = 4'd3; i4.b = 4'd3;
    end
    i4.in_valid = 1'b0;
    ready_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(i4.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(i4.out_valid), 32'd0);
    chk("bp_release_p_kept", 32'(i4.p), 32'h1E);

    // Asynchronous abort in the middle of BUSY.
    send4(4'd3, 4'd5, 1'b0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_busy_before", 32'(i4.busy), 32'd1);
    rst_n = 1'b0;
    void'(exp4.pop_back()); n_push4--;
    #1;
    chk("abort_busy", 32'(i4.busy), 32'd0);
    chk("abort_out_valid", 32'(i4.out_valid), 32'd0);
    chk("abort_p", 32'(i4.p), 32'd0);
    chk("abort_in_ready", 32'(i4.in_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    send4(4'd7, 4'hD, 1'b1, 8'hEB, 1'b1);
    drain(200);

    // Every operand pair in both modes under random backpressure.
    rnd_en = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          send4(4'(x), 4'(y), 1'(m), ref4(4'(x), 4'(y), 1'(m)), 1'b0);
    rnd_en = 1'b0;
    drain(500);
    repeat (5) @(posedge clk);
    chk("w4_result_count", 32'(n_res4), 32'(n_push4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
